video_cfg_ctrl: RTL and testbench



---
 rtl/video_cfg_pkg.sv | 66 ++++++
 rtl/video_cfg_ctrl_if.sv | 11 +
 rtl/video_res_lut.sv | 21 ++
 rtl/video_cfg_ctrl.sv | 140 ++++++++++++++
 tb/tb_video_cfg_ctrl.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/video_cfg_pkg.sv
// rtl/video_cfg_pkg.sv - shared constants, types and lookup tables for the video config sequencer
// Purpose: register map, vmode encoding, resolution window table, fetch-lead table
//          and commit FSM state type used by video_cfg_ctrl and video_res_lut.
package video_cfg_pkg;

  // CPU register map
  localparam logic [2:0] VCONF_A  = 3'd0;
  localparam logic [2:0] XOFFSL_A = 3'd1;
  localparam logic [2:0] XOFFSH_A = 3'd2;
  localparam logic [2:0] YOFFSL_A = 3'd3;
  localparam logic [2:0] YOFFSH_A = 3'd4;
  localparam logic [2:0] HSINT_A  = 3'd5;
  localparam logic [2:0] VSINTL_A = 3'd6;
  localparam logic [2:0] VSINTH_A = 3'd7;

  typedef enum logic [1:0] {
    VM_ZX   = 2'd0,
    VM_16C  = 2'd1,
    VM_256C = 2'd2,
    VM_TEXT = 2'd3
  } vmode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_COMMIT = 2'd2
  } cfg_state_e;

  typedef struct packed {
    logic [8:0] h_beg;
    logic [8:0] h_end;
    logic [8:0] v_beg;
    logic [8:0] v_end;
  } win_t;

  // Pixel window per resolution code, expressed as deltas from the blank-end bases.
  function automatic win_t res_window(input logic [1:0] rres,
                                      input logic [8:0] hbase,
                                      input logic [8:0] vbase);
    win_t w;
    case (rres)
      2'd0:    w = '{h_beg: hbase + 9'd52, h_end: hbase + 9'd308,
                     v_beg: vbase + 9'd48, v_end: vbase + 9'd240};
      2'd1:    w = '{h_beg: hbase + 9'd20, h_end: hbase + 9'd340,
                     v_beg: vbase + 9'd44, v_end: vbase + 9'd244};
      2'd2:    w = '{h_beg: hbase + 9'd20, h_end: hbase + 9'd340,
                     v_beg: vbase + 9'd24, v_end: vbase + 9'd264};
      default: w = '{h_beg: hbase,         h_end: hbase + 9'd360,
                     v_beg: vbase,         v_end: vbase + 9'd288};
    endcase
    return w;
  endfunction

  // DRAM fetch lead per video mode.
  function automatic logic [4:0] go_offs_of(input vmode_e vm);
    logic [4:0] g;
    case (vm)
      VM_ZX:   g = 5'd18;
      VM_16C:  g = 5'd8;
      VM_256C: g = 5'd4;
      default: g = 5'd8;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/video_cfg_ctrl_if.sv
// rtl/video_cfg_ctrl_if.sv - CPU register write bus for the video config sequencer
// Signals: reg_wr (one-clk write strobe), reg_addr (register select), reg_data (write data).
// master drives the bus (CPU side), slave receives it (video_cfg_ctrl).
interface video_cfg_ctrl_if ();
  logic       reg_wr;
  logic [2:0] reg_addr;
  logic [7:0] reg_data;

  modport master (output reg_wr, output reg_addr, output reg_data);
  modport slave  (input  reg_wr, input  reg_addr, input  reg_data);
endinterface

// File: rtl/video_res_lut.sv
// rtl/video_res_lut.sv - combinational mode/resolution to pixel window and fetch lead lookup
// Inputs:  rres (resolution code), vmode (video mode).
// Outputs: win (h/v pixel window bounds), go_offs (DRAM fetch lead).
module video_res_lut
  import video_cfg_pkg::*;
#(
  parameter logic [8:0] RES_HBASE = 9'd88,
  parameter logic [8:0] RES_VBASE = 9'd32
) (
  input  logic [1:0] rres,
  input  vmode_e     vmode,
  output win_t       win,
  output logic [4:0] go_offs
);

  always_comb begin
    win     = res_window(rres, RES_HBASE, RES_VBASE);
    go_offs = go_offs_of(vmode);
  end

endmodule

// File: rtl/video_cfg_ctrl.sv
// rtl/video_cfg_ctrl.sv - video register shadowing and raster-safe commit sequencer
// Inputs:  clk, res (async active-high), c3 (7 MHz phase), line_start_s, frame_start,
//          cpu (register write bus, slave side).
// Outputs: hpix/vpix window, go_offs, x_offs, cstart, rstart, hint_beg, vint_beg,
//          nogfx, vmode, y_offs_wr pulse, cfg_upd pulse.
module video_cfg_ctrl
  import video_cfg_pkg::*;
#(
  parameter logic [8:0] RES_VBASE = 9'd32,
  parameter logic [8:0] RES_HBASE = 9'd88,
  parameter logic [7:0] DEF_HINT  = 8'd2,
  parameter logic [8:0] DEF_VINT  = 9'd0
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic                   c3,
  input  logic                   line_start_s,
  input  logic                   frame_start,
  video_cfg_ctrl_if.slave        cpu,
  output logic [8:0]             hpix_beg,
  output logic [8:0]             hpix_end,
  output logic [8:0]             vpix_beg,
  output logic [8:0]             vpix_end,
  output logic [4:0]             go_offs,
  output logic [1:0]             x_offs,
  output logic [7:0]             cstart,
  output logic [8:0]             rstart,
  output logic [7:0]             hint_beg,
  output logic [8:0]             vint_beg,
  output logic                   nogfx,
  output logic [1:0]             vmode,
  output logic                   y_offs_wr,
  output logic                   cfg_upd
);

  localparam win_t WIN_RST = res_window(2'd0, RES_HBASE, RES_VBASE);

  cfg_state_e state, state_nxt;
  logic [7:0] vconf_shadow, vconf_active;
  logic [8:0] x_shadow, x_active;
  logic       commit_load;
  win_t       lut_win;
  logic [4:0] lut_go;

  logic wr_vconf, wr_yoffs;
  assign wr_vconf = cpu.reg_wr && (cpu.reg_addr == VCONF_A);
  assign wr_yoffs = cpu.reg_wr && ((cpu.reg_addr == YOFFSL_A) || (cpu.reg_addr == YOFFSH_A));

  // Commit FSM: a VCONF write always re-arms, even on the commit edge itself, so a
  // value written at that instant waits for the next frame.
  always_comb begin
    state_nxt   = state;
    commit_load = (state == ST_ARMED) && frame_start && c3;
    case (state)
      ST_IDLE:   state_nxt = ST_IDLE;
      ST_ARMED:  if (commit_load) state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    if (wr_vconf) state_nxt = ST_ARMED;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // cfg_upd follows the load rather than the COMMIT state so a commit that
  // coincides with a new write is still announced.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      vconf_shadow <= 8'h00;
      vconf_active <= 8'h00;
      cfg_upd      <= 1'b0;
    end else begin
      if (wr_vconf)    vconf_shadow <= cpu.reg_data;
      if (commit_load) vconf_active <= vconf_shadow;
      cfg_upd <= commit_load;
    end
  end

  video_res_lut #(.RES_HBASE(RES_HBASE), .RES_VBASE(RES_VBASE)) u_lut (
    .rres    (vconf_active[5:4]),
    .vmode   (vmode_e'(vconf_active[1:0])),
    .win     (lut_win),
    .go_offs (lut_go)
  );

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      hpix_beg <= WIN_RST.h_beg;
      hpix_end <= WIN_RST.h_end;
      vpix_beg <= WIN_RST.v_beg;
      vpix_end <= WIN_RST.v_end;
      go_offs  <= go_offs_of(VM_ZX);
    end else begin
      hpix_beg <= lut_win.h_beg;
      hpix_end <= lut_win.h_end;
      vpix_beg <= lut_win.v_beg;
      vpix_end <= lut_win.v_end;
      go_offs  <= lut_go;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      x_shadow  <= 9'd0;
      x_active  <= 9'd0;
      rstart    <= 9'd0;
      y_offs_wr <= 1'b0;
      hint_beg  <= DEF_HINT;
      vint_beg  <= DEF_VINT;
    end else begin
      if (line_start_s) x_active <= x_shadow;
      y_offs_wr <= wr_yoffs;
      if (cpu.reg_wr) begin
        case (cpu.reg_addr)
          XOFFSL_A: x_shadow[7:0] <= cpu.reg_data;
          XOFFSH_A: x_shadow[8]   <= cpu.reg_data[0];
          YOFFSL_A: rstart[7:0]   <= cpu.reg_data;
          YOFFSH_A: rstart[8]     <= cpu.reg_data[0];
          HSINT_A:  hint_beg      <= cpu.reg_data;
          VSINTL_A: vint_beg[7:0] <= cpu.reg_data;
          VSINTH_A: vint_beg[8]   <= cpu.reg_data[0];
          default:  ;
        endcase
      end
    end
  end

  assign x_offs = x_active[1:0];
  assign cstart = {1'b0, x_active[8:2]};
  assign vmode  = vconf_active[1:0];
  assign nogfx  = vconf_active[3];

  // VCONF bits 7:6 and 2 are kept for read-back compatibility but drive nothing.
  logic unused_vconf;
  assign unused_vconf = &{1'b0, vconf_active[7:6], vconf_active[2]};

endmodule

// File: tb/tb_video_cfg_ctrl.sv
// tb/tb_video_cfg_ctrl.sv - self-checking bench for video_cfg_ctrl
module tb_video_cfg_ctrl;

  logic clk = 1'b0;
  logic res, c3, line_start_s, frame_start;
  logic [8:0] hpix_beg, hpix_end, vpix_beg, vpix_end, rstart, vint_beg;
  logic [4:0] go_offs;
  logic [1:0] x_offs, vmode;
  logic [7:0] cstart, hint_beg;
  logic nogfx, y_offs_wr, cfg_upd;

  video_cfg_ctrl_if cpu_if ();

  video_cfg_ctrl dut (
    .clk(clk), .res(res), .c3(c3), .line_start_s(line_start_s), .frame_start(frame_start),
    .cpu(cpu_if),
    .hpix_beg(hpix_beg), .hpix_end(hpix_end), .vpix_beg(vpix_beg), .vpix_end(vpix_end),
    .go_offs(go_offs), .x_offs(x_offs), .cstart(cstart), .rstart(rstart),
    .hint_beg(hint_beg), .vint_beg(vint_beg), .nogfx(nogfx), .vmode(vmode),
    .y_offs_wr(y_offs_wr), .cfg_upd(cfg_upd)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference tables straight from the resolution / fetch-lead description
  logic [8:0] hb_t [4] = '{9'd140, 9'd108, 9'd108, 9'd88};
  logic [8:0] he_t [4] = '{9'd396, 9'd428, 9'd428, 9'd448};
  logic [8:0] vb_t [4] = '{9'd80,  9'd76,  9'd56,  9'd32};
  logic [8:0] ve_t [4] = '{9'd272, 9'd276, 9'd296, 9'd320};
  logic [4:0] go_t [4] = '{5'd18,  5'd8,   5'd4,   5'd8};

  // Behavioural model: a pending flag instead of a state machine
  logic [7:0] m_shadow, m_active, m_win;
  logic       m_pending, m_upd, m_yw;
  logic [8:0] m_xsh, m_xact, m_rstart, m_vint;
  logic [7:0] m_hint;

  task automatic model_reset();
    m_shadow = 8'h00; m_active = 8'h00; m_win = 8'h00; m_pending = 1'b0;
    m_upd = 1'b0; m_yw = 1'b0; m_xsh = 9'd0; m_xact = 9'd0; m_rstart = 9'd0;
    m_hint = 8'd2; m_vint = 9'd0;
  endtask

  task automatic model_step(input logic wr, input logic [2:0] a, input logic [7:0] d,
                            input logic c, input logic ls, input logic fs);
    logic commit;
    commit = m_pending && fs && c;
    m_win  = m_active;
    m_upd  = commit;
    if (commit) begin m_active = m_shadow; m_pending = 1'b0; end
    if (ls) m_xact = m_xsh;
    m_yw = wr && (a == 3'd3 || a == 3'd4);
    if (wr) begin
      case (a)
        3'd0: begin m_shadow = d; m_pending = 1'b1; end
        3'd1: m_xsh[7:0] = d;
        3'd2: m_xsh[8] = d[0];
        3'd3: m_rstart[7:0] = d;
        3'd4: m_rstart[8] = d[0];
        3'd5: m_hint = d;
        3'd6: m_vint[7:0] = d;
        default: m_vint[8] = d[0];
      endcase
    end
  endtask

  function automatic logic [127:0] exp_pack();
    int r;
    r = int'(m_win[5:4]);
    return {hb_t[r], he_t[r], vb_t[r], ve_t[r], go_t[int'(m_win[1:0])],
            m_xact[1:0], 1'b0, m_xact[8:2], m_rstart, m_hint, m_vint,
            m_active[3], m_active[1:0], m_yw, m_upd};
  endfunction

  function automatic logic [127:0] act_pack();
    return {hpix_beg, hpix_end, vpix_beg, vpix_end, go_offs, x_offs, cstart, rstart,
            hint_beg, vint_beg, nogfx, vmode, y_offs_wr, cfg_upd};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic wr, input logic [2:0] a, input logic [7:0] d,
                     input logic c, input logic ls, input logic fs);
    cpu_if.reg_wr = wr; cpu_if.reg_addr = a; cpu_if.reg_data = d;
    c3 = c; line_start_s = ls; frame_start = fs;
    @(posedge clk); #1;
    model_step(wr, a, d, c, ls, fs);
  endtask

  task automatic idle(); cyc(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0); endtask

  task automatic do_reset();
    cpu_if.reg_wr = 1'b0; cpu_if.reg_addr = 3'd0; cpu_if.reg_data = 8'h00;
    c3 = 1'b0; line_start_s = 1'b0; frame_start = 1'b0;
    res = 1'b1;
    repeat (2) @(posedge clk);
    #1 res = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [7:0] vconf;
    logic [8:0] hb, he, vb, ve;
    logic [4:0] go;
    logic       ng;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{8'h00, 9'd140, 9'd396, 9'd80, 9'd272, 5'd18, 1'b0};
    vecs[1] = '{8'h11, 9'd108, 9'd428, 9'd76, 9'd276, 5'd8,  1'b0};
    vecs[2] = '{8'h22, 9'd108, 9'd428, 9'd56, 9'd296, 5'd4,  1'b0};
    vecs[3] = '{8'h33, 9'd88,  9'd448, 9'd32, 9'd320, 5'd8,  1'b0};
    vecs[4] = '{8'h0B, 9'd140, 9'd396, 9'd80, 9'd272, 5'd8,  1'b1};
    vecs[5] = '{8'h1A, 9'd108, 9'd428, 9'd76, 9'd276, 5'd4,  1'b1};
    vecs[6] = '{8'h27, 9'd108, 9'd428, 9'd56, 9'd296, 5'd8,  1'b0};
    vecs[7] = '{8'hF0, 9'd88,  9'd448, 9'd32, 9'd320, 5'd18, 1'b0};

    do_reset();
    check("rst_hpix_beg", hpix_beg, 140);
    check("rst_hpix_end", hpix_end, 396);
    check("rst_vpix_beg", vpix_beg, 80);
    check("rst_vpix_end", vpix_end, 272);
    check("rst_go_offs", go_offs, 18);
    check("rst_pulses", {cfg_upd, y_offs_wr}, 0);
    check("rst_rstart", rstart, 0);
    check("rst_hint", hint_beg, 2);
    check("rst_vint", vint_beg, 0);
    check("rst_vmode", vmode, 0);

    // VCONF 0x31 held until frame_start & c3
    cyc(1'b1, 3'd0, 8'h31, 1'b0, 1'b0, 1'b0);
    check("arm_vmode", vmode, 0);
    cyc(1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("arm_noupd", cfg_upd, 0);
    check("arm_hpix", hpix_beg, 140);
    cyc(1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1);
    check("commit_upd", cfg_upd, 1);
    check("commit_vmode", vmode, 1);
    check("commit_lag", hpix_beg, 140);
    idle();
    check("commit_upd_end", cfg_upd, 0);
    check("commit_win", {hpix_beg, hpix_end, vpix_beg, vpix_end, go_offs},
          {9'd88, 9'd448, 9'd32, 9'd320, 5'd8});
    cyc(1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1);
    check("idle_noupd", cfg_upd, 0);

    // Write coincident with commit edge
    do_reset();
    cyc(1'b1, 3'd0, 8'h31, 1'b0, 1'b0, 1'b0);
    idle();
    cyc(1'b1, 3'd0, 8'h12, 1'b1, 1'b0, 1'b1);
    check("coin_upd1", cfg_upd, 1);
    check("coin_vmode1", vmode, 1);
    idle();
    check("coin_upd1_end", cfg_upd, 0);
    check("coin_hpix1", hpix_beg, 88);
    cyc(1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1);
    check("coin_upd2", cfg_upd, 1);
    check("coin_vmode2", vmode, 2);
    idle();
    check("coin_win2", {cfg_upd, hpix_beg, vpix_beg, go_offs}, {1'b0, 9'd108, 9'd76, 5'd4});

    // X offset waits for line start
    cyc(1'b1, 3'd1, 8'h0D, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 3'd2, 8'h01, 1'b0, 1'b0, 1'b0);
    check("x_hold", {x_offs, cstart}, 0);
    cyc(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("x_offs", x_offs, 1);
    check("x_cstart", cstart, 8'h43);

    // Y offset back-to-back writes
    cyc(1'b1, 3'd3, 8'h20, 1'b0, 1'b0, 1'b0);
    check("y_pulse1", y_offs_wr, 1);
    check("y_lo", rstart, 9'h020);
    cyc(1'b1, 3'd4, 8'hFF, 1'b0, 1'b0, 1'b0);
    check("y_pulse2", y_offs_wr, 1);
    check("y_full", rstart, 9'h120);
    idle();
    check("y_pulse_end", y_offs_wr, 0);

    // Reset while armed abandons the pending commit
    cyc(1'b1, 3'd0, 8'h03, 1'b0, 1'b0, 1'b0);
    #2 res = 1'b1;
    #1 check("async_rstart", rstart, 0);
    @(posedge clk); #1 res = 1'b0;
    model_reset();
    cyc(1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1);
    check("rst_armed_noupd", cfg_upd, 0);
    check("rst_armed_vmode", vmode, 0);

    // Table-driven window / mode vectors
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 3'd0, vecs[i].vconf, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1);
      idle();
      check($sformatf("vec%0d", i),
            {hpix_beg, hpix_end, vpix_beg, vpix_end, go_offs, vmode, nogfx},
            {vecs[i].hb, vecs[i].he, vecs[i].vb, vecs[i].ve, vecs[i].go,
             vecs[i].vconf[1:0], vecs[i].ng});
    end

    // Randomized run against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
          1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 7) == 0));
      check($sformatf("rand%0d", i), act_pack(), exp_pack());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
